// File: rtl/score_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// score_scan_ctrl_pkg
// Shared definitions for the two-player score keeper and its display scanner:
//   - digit_idx_e      : which of the four display digits is being driven
//   - ANODE_*          : active-low anode patterns for each digit, plus blank
//   - WINNER_*         : encoding of the winner output
//   - anode_pattern()  : maps a digit index onto its anode pattern
// -----------------------------------------------------------------------------
package score_scan_ctrl_pkg;

  // Scan order across the four digits.
  // Bit 1 selects the player and bit 0 selects tens versus ones.
  typedef enum logic [1:0] {
    DIG_P1_ONES = 2'd0,
    DIG_P1_TENS = 2'd1,
    DIG_P2_ONES = 2'd2,
    DIG_P2_TENS = 2'd3
  } digit_idx_e;

  // Active-low digit enables, one digit low at a time
  localparam logic [3:0] ANODE_P1_ONES = 4'b1110;
  localparam logic [3:0] ANODE_P1_TENS = 4'b1101;
  localparam logic [3:0] ANODE_P2_ONES = 4'b1011;
  localparam logic [3:0] ANODE_P2_TENS = 4'b0111;
  localparam logic [3:0] ANODE_BLANK   = 4'b1111;

  // Winner codes
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  // Anode pattern that lights the given digit
  function automatic logic [3:0] anode_pattern(input digit_idx_e idx);
    logic [3:0] pat;
    pat = ANODE_BLANK;
    case (idx)
      DIG_P1_ONES: pat = ANODE_P1_ONES;
      DIG_P1_TENS: pat = ANODE_P1_TENS;
      DIG_P2_ONES: pat = ANODE_P2_ONES;
      DIG_P2_TENS: pat = ANODE_P2_TENS;
      default:     pat = ANODE_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/score_scan_ctrl_bcd.sv
// -----------------------------------------------------------------------------
// BCD
// Purely combinational binary-to-BCD converter for a 4-bit value (0..15).
// Ports:
//   bin  [3:0] in  : binary value
//   tens [3:0] out : tens digit (0 or 1)
//   ones [3:0] out : ones digit (0..9)
// -----------------------------------------------------------------------------
module BCD (
  input  logic [3:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // A 4-bit input never exceeds 15, so one compare against 10 covers every case
  always_comb begin
    tens = 4'd0;
    ones = bin;
    if (bin >= 4'd10) begin
      tens = 4'd1;
      ones = bin - 4'd10;
    end
  end

endmodule

// File: rtl/score_scan_ctrl.sv
// -----------------------------------------------------------------------------
// score_scan_ctrl
// Keeps two player scores up to WIN_SCORE, flags the end of the game and the
// winner, and scans both scores onto a four-digit multiplexed 7-segment display
// (BCD value plus active-low anodes).
// Parameters:
//   WIN_SCORE : score that ends the game (1..15)
//   SCAN_DIV  : clocks spent on each display digit (2..2^20)
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   point_p1   in  : one-cycle pulse, player 1 scored
//   point_p2   in  : one-cycle pulse, player 2 scored
//   game_clear in  : synchronous clear of scores and game state
//   score_p1   out : player 1 score
//   score_p2   out : player 2 score
//   game_over  out : high once either score reaches WIN_SCORE
//   winner     out : 00 none, 01 P1, 10 P2, 11 draw
//   anode      out : active-low digit enables (1111 = blank)
//   seg_digit  out : BCD value of the enabled digit
// -----------------------------------------------------------------------------
module score_scan_ctrl
  import score_scan_ctrl_pkg::*;
#(
  parameter int WIN_SCORE = 11,
  parameter int SCAN_DIV  = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       game_clear,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] anode,
  output logic [3:0] seg_digit
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      WIN      = 4'(WIN_SCORE);

  logic             p1_at_win;
  logic             p2_at_win;
  logic [1:0]       win_code;
  logic [DIV_W-1:0] div_cnt;
  digit_idx_e       digit_idx;
  logic [3:0]       bcd_in;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
  logic             blank;
  logic [3:0]       next_anode;
  logic [3:0]       next_seg;

  assign p1_at_win = (score_p1 == WIN);
  assign p2_at_win = (score_p2 == WIN);

  // Winner is decided from the registered scores, so a simultaneous finish
  // naturally produces a draw.
  always_comb begin
    win_code = WINNER_NONE;
    case ({p2_at_win, p1_at_win})
      2'b01:   win_code = WINNER_P1;
      2'b10:   win_code = WINNER_P2;
      2'b11:   win_code = WINNER_DRAW;
      default: win_code = WINNER_NONE;
    endcase
  end

  // Scoring. game_clear has priority over points. Increments saturate at
  // WIN_SCORE because game_over only rises one cycle after a score lands
  // there, and a pulse arriving in that gap must not push the score past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      game_over <= 1'b0;
      winner    <= WINNER_NONE;
    end else if (game_clear) begin
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      game_over <= 1'b0;
      winner    <= WINNER_NONE;
    end else if (!game_over) begin
      if (point_p1 && !p1_at_win) score_p1 <= score_p1 + 4'd1;
      if (point_p2 && !p2_at_win) score_p2 <= score_p2 + 4'd1;
      if (p1_at_win || p2_at_win) begin
        game_over <= 1'b1;
        winner    <= win_code;
      end
    end
  end

  // Scan divider and digit index. These run freely and ignore game_clear, so
  // the display keeps its rhythm when a new game starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= DIG_P1_ONES;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx_e'(digit_idx + 2'd1);
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // A single converter is shared across the digits: index bit 1 picks the player
  assign bcd_in = digit_idx[1] ? score_p2 : score_p1;

  BCD u_bcd (
    .bin  (bcd_in),
    .tens (bcd_tens),
    .ones (bcd_ones)
  );

  // Index bit 0 picks tens or ones. A zero tens digit is blanked rather than
  // shown as a leading zero.
  always_comb begin
    blank      = digit_idx[0] && (bcd_tens == 4'd0);
    next_anode = anode_pattern(digit_idx);
    next_seg   = digit_idx[0] ? bcd_tens : bcd_ones;
    if (blank) begin
      next_anode = ANODE_BLANK;
      next_seg   = 4'd0;
    end
  end

  // Display outputs are registered every cycle. They follow a new digit index
  // or a score change one cycle later and otherwise stay steady through the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode     <= ANODE_BLANK;
      seg_digit <= 4'd0;
    end else begin
      anode     <= next_anode;
      seg_digit <= next_seg;
    end
  end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_scan_ctrl
// Directed self-checking bench for score_scan_ctrl with SCAN_DIV=4 and
// WIN_SCORE=11. Counts clock edges since reset release to know which digit
// slot the display should be showing.
// -----------------------------------------------------------------------------
module tb_score_scan_ctrl;

  localparam int WIN_SCORE = 11;
  localparam int SCAN_DIV  = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       point_p1   = 1'b0;
  logic       point_p2   = 1'b0;
  logic       game_clear = 1'b0;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic [1:0] winner;
  logic [3:0] anode;
  logic [3:0] seg_digit;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  logic [3:0] idle_anode [4];

  score_scan_ctrl #(
    .WIN_SCORE (WIN_SCORE),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .game_clear (game_clear),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over),
    .winner     (winner),
    .anode      (anode),
    .seg_digit  (seg_digit)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Edges since reset release. After edge n the display shows slot ((n-1)/4)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given inputs for exactly one edge, then return them to idle
  task automatic applyStimulus(input logic p1, input logic p2, input logic clr);
    point_p1   = p1;
    point_p2   = p2;
    game_clear = clr;
    tick();
    point_p1   = 1'b0;
    point_p2   = 1'b0;
    game_clear = 1'b0;
  endtask

  // Repeated point pulses
  task automatic pulses(input logic p1, input logic p2, input int count);
    for (int k = 0; k < count; k++) applyStimulus(p1, p2, 1'b0);
  endtask

  // Idle until the second cycle of the requested digit slot (bounded by one scan)
  task automatic waitSlot(input int slot);
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      tick();
      if (((n - 1) % (4 * SCAN_DIV)) == slot * SCAN_DIV + 1) break;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    idle_anode[0] = 4'b1110;
    idle_anode[1] = 4'b1111;
    idle_anode[2] = 4'b1011;
    idle_anode[3] = 4'b1111;

    // Reset state
    #22;
    checkOutput("rst_score_p1", score_p1, 4'd0);
    checkOutput("rst_score_p2", score_p2, 4'd0);
    checkOutput("rst_game_over", game_over, 1'b0);
    checkOutput("rst_winner", winner, 2'b00);
    checkOutput("rst_anode", anode, 4'b1111);
    checkOutput("rst_seg", seg_digit, 4'd0);
    rst_n = 1'b1;

    // Three points for P1: ones digit 3, tens blanked
    pulses(1'b1, 1'b0, 3);
    checkOutput("p1_three", score_p1, 4'd3);
    waitSlot(0);
    checkOutput("p1_ones_anode", anode, 4'b1110);
    checkOutput("p1_ones_seg", seg_digit, 4'd3);
    waitSlot(1);
    checkOutput("p1_tens_blank_anode", anode, 4'b1111);
    checkOutput("p1_tens_blank_seg", seg_digit, 4'd0);

    // P2 to 10: tens shows 1, ones shows 0
    pulses(1'b0, 1'b1, 10);
    checkOutput("p2_ten", score_p2, 4'd10);
    waitSlot(3);
    checkOutput("p2_tens_anode", anode, 4'b0111);
    checkOutput("p2_tens_seg", seg_digit, 4'd1);
    waitSlot(2);
    checkOutput("p2_ones_anode", anode, 4'b1011);
    checkOutput("p2_ones_seg", seg_digit, 4'd0);

    // P1 to 10, then a simultaneous point: draw one cycle later
    pulses(1'b1, 1'b0, 7);
    checkOutput("p1_ten", score_p1, 4'd10);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("draw_score_p1", score_p1, 4'd11);
    checkOutput("draw_score_p2", score_p2, 4'd11);
    checkOutput("draw_go_lag", game_over, 1'b0);
    tick();
    checkOutput("draw_game_over", game_over, 1'b1);
    checkOutput("draw_winner", winner, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("draw_hold_p1", score_p1, 4'd11);
    checkOutput("draw_hold_winner", winner, 2'b11);
    waitSlot(1);
    checkOutput("p1_tens11_anode", anode, 4'b1101);
    checkOutput("p1_tens11_seg", seg_digit, 4'd1);

    // Clear, then P1 wins; a pulse in the gap before game_over must saturate
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_score_p1", score_p1, 4'd0);
    checkOutput("clr_score_p2", score_p2, 4'd0);
    checkOutput("clr_game_over", game_over, 1'b0);
    checkOutput("clr_winner", winner, 2'b00);
    pulses(1'b1, 1'b0, 11);
    checkOutput("p1_eleven", score_p1, 4'd11);
    checkOutput("p1_eleven_go_lag", game_over, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("p1_saturate", score_p1, 4'd11);
    checkOutput("p1_win_game_over", game_over, 1'b1);
    checkOutput("p1_win_winner", winner, 2'b01);
    pulses(1'b0, 1'b1, 3);
    checkOutput("over_p2_ignored", score_p2, 4'd0);
    checkOutput("over_winner_hold", winner, 2'b01);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clr_pri_score_p1", score_p1, 4'd0);
    checkOutput("clr_pri_game_over", game_over, 1'b0);
    checkOutput("clr_pri_winner", winner, 2'b00);

    // Asynchronous reset mid-slot at digit index 2
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitSlot(2);
    checkOutput("pre_rst_anode", anode, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_anode", anode, 4'b1111);
    checkOutput("async_rst_score_p2", score_p2, 4'd0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("restart_anode", anode, 4'b1110);

    // Free run with a game_clear midway that must not disturb the scan
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 10));
      checkOutput($sformatf("run_anode_%0d", i), anode,
                  idle_anode[((n - 1) / SCAN_DIV) % 4]);
      checkOutput($sformatf("run_seg_%0d", i), seg_digit, 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_scan_ctrl.md
SCORE_SCAN_CTRL -- requirements
Module: score_scan_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11: score at which a game ends; legal range 1..15.
REQ-002 Parameter SCAN_DIV, default 100000: clocks per digit-scan slot; legal range 2..2^20.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 point_p1  input  1  one-cycle pulse: player 1 scored.
REQ-006 point_p2  input  1  one-cycle pulse: player 2 scored.
REQ-007 game_clear  input  1  synchronous clear of scores and game state.
REQ-008 score_p1  output  4  registered player 1 score.
REQ-009 score_p2  output  4  registered player 2 score.
REQ-010 game_over  output  1  high once either score reaches WIN_SCORE.
REQ-011 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-012 anode  output  4  active-low digit enables, one-hot-low or all-ones (blank).
REQ-013 seg_digit  output  4  BCD value (0..9) for the currently enabled digit.

Function
REQ-014 While game_over=0, point_p1 increments score_p1 by 1 and point_p2 increments score_p2 by 1 in the same cycle the pulse is sampled.
REQ-015 Simultaneous point_p1 and point_p2 increment both scores in the same cycle.
REQ-016 Scores never exceed WIN_SCORE; no wrap-around under any input sequence.
REQ-017 game_over and winner update in the cycle after the score reaching WIN_SCORE is registered; both reaching it in the same cycle yields winner=11.
REQ-018 While game_over=1, point pulses are ignored; scores, winner and game_over hold.
REQ-019 game_clear sets scores, winner, game_over to 0 on the next edge and overrides point pulses in the same cycle.
REQ-020 Scan divider counts 0..SCAN_DIV-1 and wraps; terminal count advances a 2-bit digit index 0->1->2->3->0.
REQ-021 Digit index map: 0 = P1 ones (anode 1110), 1 = P1 tens (1101), 2 = P2 ones (1011), 3 = P2 tens (0111).
REQ-022 One shared BCD converter instance is time-multiplexed: input = score_p1 when index bit1=0, else score_p2; output tens/ones chosen by index bit0.
REQ-023 anode and seg_digit are registered, valid one cycle after the digit index changes; both hold constant for the remainder of the slot.
REQ-024 Leading-zero blanking: on a tens slot whose tens value is 0, anode=1111 and seg_digit=0.
REQ-025 Score changes mid-slot appear on anode/seg_digit one cycle after the score register updates.
REQ-026 game_clear does not affect the divider or digit index.

Reset
REQ-027 rst_n low asynchronously forces score_p1=0, score_p2=0, game_over=0, winner=00, anode=1111, seg_digit=0, divider=0, digit index=0.
REQ-028 Reset deassertion mid-slot restarts scanning at index 0 with a full SCAN_DIV slot; first valid anode (1110) appears one cycle after deassertion.

Structure
REQ-029 Shared package holds the digit-index encoding, the four anode patterns, ANODE_BLANK=1111 and the winner codes.
REQ-030 Exactly one sub-module: the team's BCD converter BCD, instantiated once; scoring and scan logic stay in score_scan_ctrl.

Verification (SCAN_DIV=4 for the bench)
REQ-031 Reset, then 3 point_p1 pulses -> score_p1=3; P1 ones slot shows anode=1110, seg_digit=3; P1 tens slot shows anode=1111.
REQ-032 Drive score_p2 to 10 -> P2 tens slot anode=0111, seg_digit=1; P2 ones slot anode=1011, seg_digit=0.
REQ-033 P1 to 10, P2 to 10, then simultaneous pulses -> both scores 11, game_over=1, winner=11 one cycle later.
REQ-034 After game_over with winner=01, further point_p2 pulses -> score_p2 unchanged; game_clear asserted with point_p1 in the same cycle -> all scores 0, game_over=0, winner=00.
REQ-035 rst_n asserted mid-slot at digit index 2 -> anode=1111 immediately (asynchronously); after release, index restarts at 0 and anode=1110.
REQ-036 Free-run 40 cycles -> anode cycles 1110, 1101 (or 1111), 1011, 0111 (or 1111), each held exactly 4 cycles.
